// File: rtl/fix_point_pkg.sv
// ---------------------------------------------------------------------------
// fix_point_pkg
// Shared definitions for the sign-magnitude fixed-point datapath (multiplier
// and divider). Words are sign-magnitude: MSB is the sign, the remaining
// N-1 bits are the magnitude with FRACTIONAL_BITS fraction bits.
//   N_DEF        default total word width (incl. sign)
//   FRAC_DEF     default number of fraction bits
//   MAG_MAX      largest magnitude for the default width (2^(N-1)-1)
//   div_state_t  divider control states
// ---------------------------------------------------------------------------
package fix_point_pkg;

    localparam int N_DEF    = 16;
    localparam int FRAC_DEF = 13;

    localparam logic [N_DEF-2:0] MAG_MAX = {(N_DEF-1){1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Result sign of a product/quotient; a zero magnitude is always positive
    // so that no negative zero is ever produced.
    function automatic logic sm_result_sign(input logic sign_a,
                                            input logic sign_b,
                                            input logic mag_is_zero);
        return (sign_a ^ sign_b) & ~mag_is_zero;
    endfunction

endpackage

// File: rtl/fix_point_divider_if.sv
// ---------------------------------------------------------------------------
// fix_point_divider_if
// Operand/result handshake bundle of the fixed-point divider.
//   in_valid / in_ready   operand handshake (a, b sign-magnitude, N bits)
//   out_valid / out_ready result handshake (quo, overflow, div_by_zero)
// Modports: master = producer/consumer side, slave = divider side.
// ---------------------------------------------------------------------------
interface fix_point_divider_if #(
    parameter int N = fix_point_pkg::N_DEF
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] quo;
    logic         overflow;
    logic         div_by_zero;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, quo, overflow, div_by_zero
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, quo, overflow, div_by_zero
    );
endinterface

// File: rtl/fix_point_divider.sv
// ---------------------------------------------------------------------------
// fix_point_divider
// Iterative sign-magnitude fixed-point divider, quo = a / b, one quotient bit
// per clock (restoring division, MSB first). Same Q format on a, b and quo.
// Ports:
//   clk    rising-edge clock
//   rstn   asynchronous active-low reset (aborts any divide in flight)
//   bus    fix_point_divider_if.slave:
//            in_valid/in_ready  accept a, b while idle
//            out_valid/out_ready result held until consumed
//            quo                quotient (truncated toward zero)
//            overflow           magnitude saturated to all ones
//            div_by_zero        |b| == 0, magnitude all ones
// ---------------------------------------------------------------------------
module fix_point_divider
    import fix_point_pkg::*;
#(
    parameter int N               = N_DEF,
    parameter int FRACTIONAL_BITS = FRAC_DEF
) (
    input  logic                clk,
    input  logic                rstn,
    fix_point_divider_if.slave  bus
);

    localparam int ITER = N - 1 + FRACTIONAL_BITS;
    localparam int CW   = $clog2(ITER);

    localparam logic [N-2:0]  MAG_ALL_ONES = {(N-1){1'b1}};
    localparam logic [CW-1:0] CNT_START    = CW'(ITER - 1);
    localparam logic [CW-1:0] CNT_ZERO     = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE      = {{(CW-1){1'b0}}, 1'b1};

    div_state_t      state_r;
    div_state_t      state_nxt_s;
    logic [CW-1:0]   cnt_r;
    logic [ITER-1:0] num_r;
    logic [N-1:0]    rem_r;
    logic [ITER-1:0] q_r;
    logic [N-2:0]    dvs_r;
    logic            sign_r;
    logic [N-1:0]    quo_r;
    logic            ovf_r;
    logic            dbz_r;
    logic            in_ready_r;
    logic            out_valid_r;

    logic            accept_s;
    logic            zero_div_s;
    logic [N-1:0]    rem_shift_s;
    logic            rem_ge_s;
    logic [N-1:0]    rem_nxt_s;
    logic [ITER-1:0] q_nxt_s;
    logic            q_hi_nz_s;
    logic [N-2:0]    mag_s;
    logic            unused_s;

    assign accept_s   = bus.in_valid & in_ready_r;
    assign zero_div_s = (bus.b[N-2:0] == {(N-1){1'b0}});

    // The remainder is always below |b| < 2^(N-1), so its top bit never carries information.
    assign unused_s = rem_r[N-1];

    // One restoring step: bring in the next numerator bit, subtract |b| when it fits.
    always_comb begin
        rem_shift_s = {rem_r[N-2:0], num_r[ITER-1]};
        rem_ge_s    = (rem_shift_s >= {1'b0, dvs_r});
        if (rem_ge_s) begin
            rem_nxt_s = rem_shift_s - {1'b0, dvs_r};
        end else begin
            rem_nxt_s = rem_shift_s;
        end
        q_nxt_s   = {q_r[ITER-2:0], rem_ge_s};
        // Any quotient bit above the magnitude field means the result does not fit.
        q_hi_nz_s = |q_nxt_s[ITER-1:N-1];
        if (q_hi_nz_s) begin
            mag_s = MAG_ALL_ONES;
        end else begin
            mag_s = q_nxt_s[N-2:0];
        end
    end

    // Next-state logic of the divide controller.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (zero_div_s) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = CALC;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register with handshake outputs registered from the next state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == IDLE);
            out_valid_r <= (state_nxt_s == DONE);
        end
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r  <= CNT_ZERO;
            num_r  <= {ITER{1'b0}};
            rem_r  <= {N{1'b0}};
            q_r    <= {ITER{1'b0}};
            dvs_r  <= {(N-1){1'b0}};
            sign_r <= 1'b0;
            quo_r  <= {N{1'b0}};
            ovf_r  <= 1'b0;
            dbz_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        num_r  <= {bus.a[N-2:0], {FRACTIONAL_BITS{1'b0}}};
                        rem_r  <= {N{1'b0}};
                        q_r    <= {ITER{1'b0}};
                        dvs_r  <= bus.b[N-2:0];
                        sign_r <= bus.a[N-1] ^ bus.b[N-1];
                        cnt_r  <= CNT_START;
                        if (zero_div_s) begin
                            // Saturated magnitude is never zero, so the sign is kept.
                            quo_r <= {bus.a[N-1] ^ bus.b[N-1], MAG_ALL_ONES};
                            dbz_r <= 1'b1;
                            ovf_r <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    num_r <= {num_r[ITER-2:0], 1'b0};
                    rem_r <= rem_nxt_s;
                    q_r   <= q_nxt_s;
                    cnt_r <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ZERO) begin
                        quo_r <= {sm_result_sign(sign_r, 1'b0, mag_s == {(N-1){1'b0}}), mag_s};
                        ovf_r <= q_hi_nz_s;
                        dbz_r <= 1'b0;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        quo_r  <= {N{1'b0}};
                        ovf_r  <= 1'b0;
                        dbz_r  <= 1'b0;
                        num_r  <= {ITER{1'b0}};
                        rem_r  <= {N{1'b0}};
                        q_r    <= {ITER{1'b0}};
                        dvs_r  <= {(N-1){1'b0}};
                        sign_r <= 1'b0;
                    end
                end
                default: begin
                    cnt_r <= CNT_ZERO;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.quo         = quo_r;
    assign bus.overflow    = ovf_r;
    assign bus.div_by_zero = dbz_r;

endmodule
